// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Register-file controller sitting behind the SPI slave byte engine. It turns
// completed bytes into a command/address/data protocol that writes a bank of
// NUM_REGS 8-bit registers. It also presents a read-back byte to the engine
// for the next transaction, and counts transactions aborted mid-byte.
//
// Ports
//   clk        master clock (shared with the SPI engine)
//   rst        asynchronous active-high reset
//   spi_csb    raw SPI chip select, active low, asynchronous to clk
//   rdy        engine byte-ready: high when idle or at byte end, low while shifting
//   rd_data    last completed received byte
//   wr_data    byte the engine shifts out at the next transaction start
//   xfer_len   transfer length for the engine, fixed at 8
//   status_in  status byte returned when STATUS_ADDR is read
//   reg_out    flattened register bank, reg n at bits [8n+7:8n]
//   wr_strobe  one-clk pulse per data byte written (including ignored addresses)
//   wr_addr    address of the current/last write
//   err_cnt    saturating count of aborted transactions
module spi_reg_ctrl #(
  parameter int         NUM_REGS    = 16,
  parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_csb,
  input  logic                  rdy,
  input  logic [7:0]            rd_data,
  output logic [7:0]            wr_data,
  output logic [3:0]            xfer_len,
  input  logic [7:0]            status_in,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RSKIP
  } state_e;

  logic [1:0] csb_sync_q;
  logic [1:0] sync_vld_q;
  logic       csb_s_d_q;
  logic       rdy_d_q;
  logic       armed_q;

  state_e     state_q;
  logic [6:0] waddr_q;
  logic [6:0] rd_ptr_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] err_cnt_q;
  logic       wr_strobe_q;
  logic [7:0] regs_q [NUM_REGS];

  logic       csb_s;
  logic       byte_evt;
  logic       csb_rise;
  logic       csb_fall;
  logic [7:0] wr_data_d;

  assign csb_s    = csb_sync_q[1];
  assign byte_evt = rdy & ~rdy_d_q & ~csb_s;
  assign csb_rise = csb_s & ~csb_s_d_q;
  assign csb_fall = ~csb_s & csb_s_d_q;

  // Chip-select synchroniser and edge history. The synchroniser resets to
  // "deselected", so if the host keeps csb low across a reset, the output
  // would show a fake falling edge once real samples arrive. sync_vld_q marks
  // when the pipeline holds genuine samples. armed_q is set only after a
  // genuine deselected level has been seen, so a transaction interrupted by
  // reset stays ignored until the host starts a fresh one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb_sync_q <= 2'b11;
      sync_vld_q <= 2'b00;
      csb_s_d_q  <= 1'b1;
      rdy_d_q    <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      csb_sync_q <= {csb_sync_q[0], spi_csb};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      csb_s_d_q  <= csb_s;
      rdy_d_q    <= rdy;
      if (sync_vld_q[1] && csb_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Read-back selection. In-range register addresses take precedence, then
  // the status address, and anything else reads as zero.
  always_comb begin
    wr_data_d = 8'h00;
    if (rd_ptr_q == STATUS_ADDR) begin
      wr_data_d = status_in;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_ptr_q == 7'(i)) begin
        wr_data_d = regs_q[i];
      end
    end
  end

  // Protocol FSM with its registered outputs. Chip-select release always
  // returns to IDLE. If a byte was mid-shift at that moment (rdy low), the
  // transaction counts as aborted. wr_data only follows the read mux while
  // idle, because the engine latches it while deselected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      waddr_q     <= 7'd0;
      rd_ptr_q    <= 7'd0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
      err_cnt_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      if (state_q == IDLE) begin
        wr_data_q <= wr_data_d;
      end
      if (csb_rise) begin
        state_q <= IDLE;
        if (!rdy_d_q && err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (csb_fall && armed_q) begin
              state_q <= CMD;
            end
          end
          CMD: begin
            if (byte_evt) begin
              if (rd_data[7]) begin
                waddr_q <= rd_data[6:0];
                state_q <= WDATA;
              end else begin
                rd_ptr_q <= rd_data[6:0];
                state_q  <= RSKIP;
              end
            end
          end
          WDATA: begin
            // Every data byte strobes, even when its address maps to no
            // register. The address auto-increments with 7-bit wrap.
            if (byte_evt) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr_q == 7'(i) && waddr_q != STATUS_ADDR) begin
                  regs_q[i] <= rd_data;
                end
              end
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= waddr_q;
              waddr_q     <= waddr_q + 7'd1;
            end
          end
          RSKIP: begin
            state_q <= RSKIP;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign wr_data   = wr_data_q;
  assign xfer_len  = 4'd8;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl
// Drives spi_reg_ctrl with an abstract SPI engine (chip select plus rdy/rd_data
// byte handshakes). Results are compared against a transaction-level model of
// the register bank, read pointer, write address and abort counter.
module tb_spi_reg_ctrl;

  localparam int NUM_REGS = 16;

  logic                  clk;
  logic                  rst;
  logic                  spi_csb;
  logic                  rdy;
  logic [7:0]            rd_data;
  logic [7:0]            wr_data;
  logic [3:0]            xfer_len;
  logic [7:0]            status_in;
  logic [8*NUM_REGS-1:0] reg_out;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;
  logic [7:0]            err_cnt;

  spi_reg_ctrl #(
    .NUM_REGS   (NUM_REGS),
    .STATUS_ADDR(7'h7F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_csb  (spi_csb),
    .rdy      (rdy),
    .rd_data  (rd_data),
    .wr_data  (wr_data),
    .xfer_len (xfer_len),
    .status_in(status_in),
    .reg_out  (reg_out),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .err_cnt  (err_cnt)
  );

  int         checkCount  = 0;
  int         errorCount  = 0;
  int         strobeCount = 0;
  logic [7:0] modelRegs [NUM_REGS];
  logic [6:0] modelRdPtr;
  logic [6:0] modelWrAddr;
  int         modelErr;
  logic [7:0] lastResp;
  logic [7:0] txQ [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses as they were seen before each rising edge.
  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobeCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [8*NUM_REGS-1:0] modelVector();
    logic [8*NUM_REGS-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = modelRegs[i];
    return v;
  endfunction

  function automatic logic [7:0] modelResp();
    if (int'(modelRdPtr) < NUM_REGS) return modelRegs[int'(modelRdPtr)];
    if (modelRdPtr == 7'h7F) return status_in;
    return 8'h00;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 8'h00;
    modelRdPtr  = 7'd0;
    modelWrAddr = 7'd0;
    modelErr    = 0;
  endtask

  task automatic setTx(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                       input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00);
    txQ.delete();
    if (n > 0) txQ.push_back(b0);
    if (n > 1) txQ.push_back(b1);
    if (n > 2) txQ.push_back(b2);
    if (n > 3) txQ.push_back(b3);
  endtask

  // One byte on the wire: rdy low for 8 clocks, then the byte completes. Returns
  // one negedge after rdy rises, when the controller's reaction is visible.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rdy = 1'b0;
    repeat (8) @(negedge clk);
    rd_data = b;
    rdy     = 1'b1;
    @(negedge clk);
  endtask

  // Full transaction of the bytes in txQ, optionally followed by a partial
  // byte cut short by chip-select release.
  task automatic applyStimulus(input bit abortLast);
    bit         isWrite;
    logic [6:0] addr;
    int         startStrobes;
    int         expStrobes;
    isWrite    = 1'b0;
    addr       = 7'd0;
    expStrobes = 0;
    @(negedge clk);
    lastResp = wr_data;
    checkOutput("resp", 128'(wr_data), 128'(modelResp()));
    startStrobes = strobeCount;
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
    foreach (txQ[k]) begin
      sendByte(txQ[k]);
      if (k == 0) begin
        isWrite = txQ[0][7];
        addr    = txQ[0][6:0];
        if (!isWrite) modelRdPtr = addr;
        checkOutput("cmdNoStrobe", 128'(wr_strobe), 128'(0));
      end else if (isWrite) begin
        if (int'(addr) < NUM_REGS) modelRegs[int'(addr)] = txQ[k];
        modelWrAddr = addr;
        expStrobes++;
        checkOutput("strobe", 128'(wr_strobe), 128'(1));
        checkOutput("wrAddr", 128'(wr_addr), 128'(addr));
        checkOutput("regBankByte", 128'(reg_out), 128'(modelVector()));
        addr = addr + 7'd1;
      end
    end
    if (abortLast) begin
      @(negedge clk);
      rdy = 1'b0;
      repeat (3) @(negedge clk);
      spi_csb = 1'b1;
      repeat (4) @(negedge clk);
      rd_data = 8'($urandom);
      rdy     = 1'b1;
      if (modelErr < 255) modelErr++;
    end else begin
      spi_csb = 1'b1;
    end
    status_in = 8'($urandom);
    repeat (8) @(negedge clk);
    checkOutput("regBank", 128'(reg_out), 128'(modelVector()));
    checkOutput("errCnt", 128'(err_cnt), 128'(modelErr));
    checkOutput("strobeCount", 128'(strobeCount - startStrobes), 128'(expStrobes));
    checkOutput("lastWrAddr", 128'(wr_addr), 128'(modelWrAddr));
    checkOutput("strobeIdle", 128'(wr_strobe), 128'(0));
  endtask

  initial begin
    int         kind;
    int         pick;
    int         n;
    int         startStrobes;
    logic [6:0] a;

    rst       = 1'b1;
    spi_csb   = 1'b1;
    rdy       = 1'b1;
    rd_data   = 8'h00;
    status_in = 8'h3C;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    checkOutput("rstRegs", 128'(reg_out), 128'(0));
    checkOutput("rstWrData", 128'(wr_data), 128'(0));
    checkOutput("rstErr", 128'(err_cnt), 128'(0));
    checkOutput("rstStrobe", 128'(wr_strobe), 128'(0));
    checkOutput("rstWrAddr", 128'(wr_addr), 128'(0));
    checkOutput("xferLen", 128'(xfer_len), 128'(4'd8));

    setTx(2, 8'h83, 8'h5A);
    applyStimulus(1'b0);
    checkOutput("reg3", 128'(reg_out[31:24]), 128'(8'h5A));

    setTx(4, 8'h8E, 8'h11, 8'h22, 8'h33);
    applyStimulus(1'b0);
    checkOutput("reg14", 128'(reg_out[119:112]), 128'(8'h11));
    checkOutput("reg15", 128'(reg_out[127:120]), 128'(8'h22));
    checkOutput("reg0Untouched", 128'(reg_out[7:0]), 128'(8'h00));

    setTx(3, 8'hFF, 8'hAA, 8'hBB);
    applyStimulus(1'b0);
    checkOutput("reg0Wrap", 128'(reg_out[7:0]), 128'(8'hBB));

    setTx(2, 8'h85, 8'hC3);
    applyStimulus(1'b0);
    setTx(1, 8'h05);
    applyStimulus(1'b0);
    setTx(1, 8'h7F);
    applyStimulus(1'b0);
    checkOutput("readReg5", 128'(lastResp), 128'(8'hC3));
    status_in = 8'hA5;
    repeat (3) @(negedge clk);
    setTx(1, 8'h20);
    applyStimulus(1'b0);
    checkOutput("readStatus", 128'(lastResp), 128'(8'hA5));
    setTx(1, 8'h00);
    applyStimulus(1'b0);
    checkOutput("readUnmapped", 128'(lastResp), 128'(8'h00));

    setTx(1, 8'h82);
    applyStimulus(1'b1);
    checkOutput("abortReg2", 128'(reg_out[23:16]), 128'(8'h00));
    checkOutput("abortErr1", 128'(err_cnt), 128'(8'd1));

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      pick = $urandom_range(0, 3);
      case (pick)
        0:       a = 7'($urandom_range(0, 15));
        1:       a = 7'($urandom_range(12, 15));
        2:       a = 7'h7F - 7'($urandom_range(0, 1));
        default: a = 7'($urandom);
      endcase
      txQ.delete();
      if (kind == 1) begin
        txQ.push_back({1'b0, a});
        applyStimulus(1'b0);
      end else begin
        txQ.push_back({1'b1, a});
        n = $urandom_range(0, 4);
        repeat (n) txQ.push_back(8'($urandom));
        applyStimulus(kind == 2);
      end
    end

    for (int t = 0; t < 299; t++) begin
      setTx(1, 8'h82);
      applyStimulus(1'b1);
    end
    checkOutput("errSaturated", 128'(err_cnt), 128'(8'hFF));

    @(negedge clk);
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
    sendByte(8'h84);
    sendByte(8'h77);
    modelRegs[4] = 8'h77;
    checkOutput("preResetReg4", 128'(reg_out[39:32]), 128'(8'h77));
    #1 rst = 1'b1;
    #2;
    modelReset();
    checkOutput("asyncRstRegs", 128'(reg_out), 128'(0));
    checkOutput("asyncRstErr", 128'(err_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    startStrobes = strobeCount;
    sendByte(8'h81);
    sendByte(8'h99);
    sendByte(8'h55);
    checkOutput("postRstNoWrite", 128'(reg_out), 128'(0));
    checkOutput("postRstNoStrobe", 128'(strobeCount - startStrobes), 128'(0));
    @(negedge clk);
    spi_csb = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("postRstErr", 128'(err_cnt), 128'(0));
    setTx(2, 8'h81, 8'h99);
    applyStimulus(1'b0);
    checkOutput("freshTxReg1", 128'(reg_out[15:8]), 128'(8'h99));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
